// File: rtl/fp32_pkg.sv
// Shared definitions for the single-precision adder sharing logic.
// No logic of its own; constants and the per-requester slot state type.
// Backpressure: not applicable.
package fp32_pkg;

    localparam int FP32_W       = 32;
    localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC00000;
    localparam int MAX_ADD_LAT  = 4;
    localparam int MAX_NUM_REQ  = 8;

    // Lifecycle of one requester's single outstanding operation
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } slot_state_t;

endpackage

// File: rtl/fp32_rr_arbiter.sv
// Round-robin pick: first eligible index at or after the pointer, modulo NUM_REQ.
// Purely combinational, zero latency.
// No backpressure; an empty eligible vector yields no grant.
module fp32_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any_grant
);

    logic [IDX_W:0] w_cand;

    // Scan from farthest to nearest candidate so the nearest eligible one wins
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (i_eligible[w_cand[IDX_W-1:0]]) begin
                o_grant                       = '0;
                o_grant[w_cand[IDX_W-1:0]]    = 1'b1;
                o_grant_idx                   = w_cand[IDX_W-1:0];
                o_any_grant                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp32_add_arbiter.sv
// Shares one fp32 adder among NUM_REQ requesters, round-robin, one issue per cycle; optional stats via FP32_ADD_ARB_STATS_EN.
// Latency: accept at edge t gives rsp_valid after edge t+ADD_LAT; repeat interval per requester ADD_LAT+2.
// Backpressure: a held response (rsp_ready low) keeps that requester's req_ready low; others continue.
module fp32_add_arbiter
    import fp32_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ADD_LAT = 1,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [FP32_W*NUM_REQ-1:0] req_a,
    input  logic [FP32_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [FP32_W*NUM_REQ-1:0] rsp_result,
    output logic [NUM_REQ-1:0]        rsp_invalid,
    output logic [FP32_W-1:0]         add_a,
    output logic [FP32_W-1:0]         add_b,
    output logic                      add_issue,
    input  logic [FP32_W-1:0]         add_result,
    input  logic                      add_invalid
`ifdef FP32_ADD_ARB_STATS_EN
    ,
    output logic [31:0]               stat_issue,
    output logic [31:0]               stat_invalid
`endif
);

    slot_state_t          r_slot       [NUM_REQ];
    slot_state_t          w_slot_nxt   [NUM_REQ];
    logic [NUM_REQ-1:0]   w_cap_en;
    logic [FP32_W-1:0]    r_rsp_result [NUM_REQ];
    logic [NUM_REQ-1:0]   r_rsp_invalid;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [ADD_LAT-1:0]   r_tag_vld;
    logic [IDX_W-1:0]     r_tag_idx    [ADD_LAT];

    logic [NUM_REQ-1:0]   w_eligible;
    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_accept;
    logic                 w_cap;
    logic [IDX_W-1:0]     w_cap_idx;

    // Only idle slots may compete; nothing is granted while reset is held
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = req_valid[i] & (r_slot[i] == IDLE) & ~rst;
        end
    end

    fp32_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_eligible  (w_eligible),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_accept)
    );

    assign req_ready = w_grant;
    assign add_issue = w_accept;
    assign w_cap     = r_tag_vld[ADD_LAT-1];
    assign w_cap_idx = r_tag_idx[ADD_LAT-1];

    // Operand mux from the granted requester, zero when idle
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (w_accept) begin
            add_a = req_a[FP32_W*int'(w_grant_idx) +: FP32_W];
            add_b = req_b[FP32_W*int'(w_grant_idx) +: FP32_W];
        end
    end

    // Per-requester slot next-state and result capture enables
    always_comb begin
        w_cap_en = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_slot_nxt[i] = r_slot[i];
            case (r_slot[i])
                IDLE: if (w_accept && (w_grant_idx == IDX_W'(i))) w_slot_nxt[i] = BUSY;
                BUSY: if (w_cap && (w_cap_idx == IDX_W'(i))) begin
                    w_slot_nxt[i] = DONE;
                    w_cap_en[i]   = 1'b1;
                end
                DONE: if (rsp_ready[i]) w_slot_nxt[i] = IDLE;
                default: w_slot_nxt[i] = IDLE;
            endcase
        end
    end

    // Slot state and held responses; reset drops any held result
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                r_slot[i]        <= IDLE;
                r_rsp_result[i]  <= '0;
                r_rsp_invalid[i] <= 1'b0;
            end else begin
                r_slot[i] <= w_slot_nxt[i];
                if (w_cap_en[i]) begin
                    r_rsp_result[i]  <= add_result;
                    r_rsp_invalid[i] <= add_invalid;
                end
            end
        end
    end

    // Round-robin pointer moves past the winner only when something is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_grant_idx + IDX_W'(1);
        end
    end

    // Tag pipeline mirrors the adder latency so results find their owner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int s = 0; s < ADD_LAT; s++) r_tag_idx[s] <= '0;
        end else begin
            r_tag_vld[0] <= w_accept;
            r_tag_idx[0] <= w_grant_idx;
            for (int s = 1; s < ADD_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end
        end
    end

    // Flatten slot registers onto the response ports
    always_comb begin
        rsp_result = '0;
        rsp_valid  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i]                    = (r_slot[i] == DONE);
            rsp_result[FP32_W*i +: FP32_W]  = r_rsp_result[i];
        end
    end
    assign rsp_invalid = r_rsp_invalid;

`ifdef FP32_ADD_ARB_STATS_EN
    logic [31:0] r_stat_issue;
    logic [31:0] r_stat_invalid;

    // Free-running wrap-around counters of issues and invalid results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_issue   <= '0;
            r_stat_invalid <= '0;
        end else begin
            if (w_accept) r_stat_issue <= r_stat_issue + 32'd1;
            if (w_cap && add_invalid) r_stat_invalid <= r_stat_invalid + 32'd1;
        end
    end
    assign stat_issue   = r_stat_issue;
    assign stat_invalid = r_stat_invalid;
`endif

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Directed bench: default instance (4 requesters, latency 1) plus a 5-requester latency-3 instance.
// A small behavioural adder with matching latency feeds each instance.
// Optional stats ports are exercised when FP32_ADD_ARB_STATS_EN is defined.
module tb_fp32_add_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance 0
    logic [3:0]   req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_invalid0;
    logic [127:0] req_a0, req_b0, rsp_result0;
    logic [31:0]  add_a0, add_b0, add_result0;
    logic         add_issue0, add_invalid0;
    // instance 1
    logic [4:0]   req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_invalid1;
    logic [159:0] req_a1, req_b1, rsp_result1;
    logic [31:0]  add_a1, add_b1, add_result1;
    logic         add_issue1, add_invalid1;
`ifdef FP32_ADD_ARB_STATS_EN
    logic [31:0]  stat_issue0, stat_invalid0, stat_issue1, stat_invalid1;
`endif

    fp32_add_arbiter #(.NUM_REQ(4), .ADD_LAT(LAT0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_a(req_a0), .req_b(req_b0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_result(rsp_result0), .rsp_invalid(rsp_invalid0),
        .add_a(add_a0), .add_b(add_b0), .add_issue(add_issue0),
        .add_result(add_result0), .add_invalid(add_invalid0)
`ifdef FP32_ADD_ARB_STATS_EN
        , .stat_issue(stat_issue0), .stat_invalid(stat_invalid0)
`endif
    );

    fp32_add_arbiter #(.NUM_REQ(5), .ADD_LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_a(req_a1), .req_b(req_b1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_result(rsp_result1), .rsp_invalid(rsp_invalid1),
        .add_a(add_a1), .add_b(add_b1), .add_issue(add_issue1),
        .add_result(add_result1), .add_invalid(add_invalid1)
`ifdef FP32_ADD_ARB_STATS_EN
        , .stat_issue(stat_issue1), .stat_invalid(stat_invalid1)
`endif
    );

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Reference adder: table of the exact sums used by the stimulus
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b)) return 32'h7FC00000;
        case ({a, b})
            64'h3F800000_3F800000: return 32'h40000000;
            64'h3F800000_40000000: return 32'h40400000;
            64'h40000000_40400000: return 32'h40A00000;
            64'h40400000_40800000: return 32'h40E00000;
            default:               return 32'h00000000;
        endcase
    endfunction

    logic [31:0] m0_res [LAT0];
    logic        m0_inv [LAT0];
    logic [31:0] m1_res [LAT1];
    logic        m1_inv [LAT1];

    always @(posedge clk) begin
        m0_res[0] <= fadd(add_a0, add_b0);
        m0_inv[0] <= is_nan(add_a0) || is_nan(add_b0);
        for (int s = 1; s < LAT0; s++) begin
            m0_res[s] <= m0_res[s-1];
            m0_inv[s] <= m0_inv[s-1];
        end
        m1_res[0] <= fadd(add_a1, add_b1);
        m1_inv[0] <= is_nan(add_a1) || is_nan(add_b1);
        for (int s = 1; s < LAT1; s++) begin
            m1_res[s] <= m1_res[s-1];
            m1_inv[s] <= m1_inv[s-1];
        end
    end
    assign add_result0  = m0_res[LAT0-1];
    assign add_invalid0 = m0_inv[LAT0-1];
    assign add_result1  = m1_res[LAT1-1];
    assign add_invalid1 = m1_inv[LAT1-1];

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a0[32*i +: 32] = a;
        req_b0[32*i +: 32] = b;
    endtask

    logic [31:0] exp2 [4];
    int last_acc [5];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid0 = 4'b0001; rsp_ready0 = '0; req_a0 = '0; req_b0 = '0;
        req_valid1 = '0; rsp_ready1 = '0; req_a1 = '0; req_b1 = '0;
        exp2[0] = 32'h40000000; exp2[1] = 32'h40400000;
        exp2[2] = 32'h40A00000; exp2[3] = 32'h40E00000;
        for (int j = 0; j < 5; j++) last_acc[j] = -100;

        // reset state, with a request held to prove it is not granted
        tick; tick; #1;
        chk("rst_req_ready", req_ready0, 0);
        chk("rst_add_issue", add_issue0, 0);
        chk("rst_add_a", add_a0, 0);
        chk("rst_add_b", add_b0, 0);
        chk("rst_rsp_valid", rsp_valid0, 0);
        chk("rst_rsp_result", rsp_result0, 0);
        chk("rst_rsp_invalid", rsp_invalid0, 0);
`ifdef FP32_ADD_ARB_STATS_EN
        chk("rst_stat_issue", stat_issue0, 0);
        chk("rst_stat_invalid", stat_invalid0, 0);
`endif
        req_valid0 = '0; rst = 1'b0;
        tick;

        // single op 1.0 + 2.0
        set_op(0, 32'h3F800000, 32'h40000000);
        req_valid0 = 4'b0001; #1;
        chk("t1_req_ready", req_ready0, 4'b0001);
        chk("t1_add_issue", add_issue0, 1);
        chk("t1_add_a", add_a0, 32'h3F800000);
        chk("t1_add_b", add_b0, 32'h40000000);
        tick; req_valid0 = '0; #1;
        chk("t1_rsp_early", rsp_valid0, 0);
        tick;
        chk("t1_rsp_valid", rsp_valid0, 4'b0001);
        chk("t1_result", rsp_result0[31:0], 32'h40400000);
        chk("t1_invalid", rsp_invalid0, 0);
        rsp_ready0 = 4'b0001; tick; rsp_ready0 = '0; #1;
        chk("t1_release", rsp_valid0, 0);

        // all four at once after reset: grants and responses in order 0..3
        rst = 1'b1; tick; rst = 1'b0;
        set_op(0, 32'h3F800000, 32'h3F800000);
        set_op(1, 32'h3F800000, 32'h40000000);
        set_op(2, 32'h40000000, 32'h40400000);
        set_op(3, 32'h40400000, 32'h40800000);
        rsp_ready0 = 4'hF; req_valid0 = 4'hF;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("t2_grant", req_ready0, (c < 4) ? (4'b0001 << c) : 4'b0000);
            chk("t2_rsp_order", rsp_valid0, (c >= 2) ? (4'b0001 << (c - 2)) : 4'b0000);
            if (c >= 2) chk("t2_result", rsp_result0[32*(c-2) +: 32], exp2[c-2]);
            tick;
            if (c < 4) req_valid0[c] = 1'b0;
        end
        chk("t2_rr_ptr", dut0.r_rr_ptr, 0);

        // backpressure on requester 2 for ten cycles
        rsp_ready0 = 4'b1011;
        set_op(2, 32'h40000000, 32'h40400000);
        req_valid0 = 4'b0100; #1;
        chk("t3_accept", req_ready0, 4'b0100);
        tick; #1;
        chk("t3_busy", rsp_valid0, 0);
        tick;
        for (int h = 0; h < 10; h++) begin
            if (h == 0) begin
                set_op(0, 32'h3F800000, 32'h3F800000);
                req_valid0[0] = 1'b1;
            end
            #1;
            chk("t3_rsp_valid", rsp_valid0, (h == 2) ? 4'b0101 : 4'b0100);
            chk("t3_req_ready", req_ready0, (h == 0) ? 4'b0001 : 4'b0000);
            chk("t3_hold_result", rsp_result0[95:64], 32'h40A00000);
            if (h == 2) chk("t3_other_result", rsp_result0[31:0], 32'h40000000);
            tick;
            if (h == 0) req_valid0[0] = 1'b0;
        end
        rsp_ready0[2] = 1'b1; #1;
        chk("t3_release_cycle_ready", req_ready0, 0);
        chk("t3_release_cycle_valid", rsp_valid0, 4'b0100);
        tick; #1;
        chk("t3_reeligible", req_ready0, 4'b0100);
        tick; req_valid0 = '0;
        tick; tick; tick;

        // NaN operand to requester 1
        rsp_ready0 = '0;
        set_op(1, 32'h7FC00000, 32'h3F800000);
        req_valid0 = 4'b0010; #1;
        chk("t4_accept", req_ready0, 4'b0010);
        tick; req_valid0 = '0;
        tick;
        chk("t4_rsp_valid", rsp_valid0, 4'b0010);
        chk("t4_invalid", rsp_invalid0, 4'b0010);
        chk("t4_result", rsp_result0[63:32], 32'h7FC00000);
`ifdef FP32_ADD_ARB_STATS_EN
        chk("t4_stat_invalid", stat_invalid0, 1);
        chk("t4_stat_issue", stat_issue0, 8);
`endif
        rsp_ready0 = 4'b0010; tick; rsp_ready0 = '0;

        // reset one cycle after accepting req3 then req1
        set_op(1, 32'h3F800000, 32'h3F800000);
        set_op(3, 32'h40400000, 32'h40800000);
        req_valid0 = 4'b1010; #1;
        chk("t5_grant3", req_ready0, 4'b1000);
        tick; req_valid0[3] = 1'b0; #1;
        chk("t5_grant1", req_ready0, 4'b0010);
        tick; req_valid0 = '0; rst = 1'b1; #1;
        chk("t5_pre_reset", rsp_valid0, 4'b1000);
        tick; rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t5_rsp_valid", rsp_valid0, 0);
            chk("t5_req_ready", req_ready0, 0);
            chk("t5_add_issue", add_issue0, 0);
            chk("t5_rsp_result", rsp_result0, 0);
            chk("t5_rsp_invalid", rsp_invalid0, 0);
            tick;
        end
        chk("t5_rr_ptr", dut0.r_rr_ptr, 0);
`ifdef FP32_ADD_ARB_STATS_EN
        chk("t5_stat_issue", stat_issue0, 0);
`endif

        // 5 requesters, latency 3, everyone always active
        for (int j = 0; j < 5; j++) begin
            req_a1[32*j +: 32] = 32'h3F800000;
            req_b1[32*j +: 32] = 32'h3F800000;
        end
        rsp_ready1 = 5'h1F; req_valid1 = 5'h1F;
        for (int c = 0; c < 40; c++) begin
            #1;
            chk("t6_onehot", $onehot0(req_ready1), 1);
            if (c >= 5) chk("t6_issue_steady", add_issue1, 1);
            for (int j = 0; j < 5; j++) begin
                if (req_ready1[j]) begin
                    chk("t6_repeat_gap", (c - last_acc[j]) >= LAT1 + 2, 1);
                    last_acc[j] = c;
                end
                if (rsp_valid1[j]) chk("t6_result", rsp_result1[32*j +: 32], 32'h40000000);
            end
            tick;
        end
        req_valid1 = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
